// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared types and op-code constants for the FPU issue/sequencing controller.
// Purely declarative: no latency.
// No backpressure of its own.
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        MUL    = 3'd1,
        DIV    = 3'd2,
        SQRT   = 3'd3,
        FMA    = 3'd4
    } op_class_e;

    localparam logic [4:0] OP_FMUL    = 5'b00010;
    localparam logic [4:0] OP_FDIV    = 5'b00011;
    localparam logic [4:0] OP_FSQRT   = 5'b01011;
    localparam logic [2:0] OP_FMA_PFX = 3'b100;

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// Core <-> FPU sequencer handshake bundle: start/op/flush in, mux/enable/stall/done out.
// Wires only: no latency.
// start is held by the core until it observes done.
interface fpu_seq_ctrl_if #(
    parameter int OP_W  = 5,
    parameter int CNT_W = 4
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic             flush;
    logic             in_sel;
    logic             reg_AB_en;
    logic             busy;
    logic             stall;
    logic             done;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, op, flush,
        input  in_sel, reg_AB_en, busy, stall, done, cnt
    );

    modport slave (
        input  start, op, flush,
        output in_sel, reg_AB_en, busy, stall, done, cnt
    );
endinterface

// File: rtl/fpu_op_class_dec.sv
// Combinational op-code to latency-class decoder, shared with the hazard unit.
// Latency: 0 cycles.
// No backpressure; a class configured with latency 1 folds into SINGLE.
module fpu_op_class_dec
    import fpu_seq_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int CNT_W    = 4,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_FMA  = 3
) (
    input  logic [OP_W-1:0]  op,
    output op_class_e        cls,
    output logic [CNT_W-1:0] lat
);

    always_comb begin
        cls = SINGLE;
        lat = CNT_W'(1);
        if (op == OP_W'(OP_FMUL) && LAT_MUL > 1) begin
            cls = MUL;
            lat = CNT_W'(LAT_MUL);
        end else if (op == OP_W'(OP_FDIV) && LAT_DIV > 1) begin
            cls = DIV;
            lat = CNT_W'(LAT_DIV);
        end else if (op == OP_W'(OP_FSQRT) && LAT_SQRT > 1) begin
            cls = SQRT;
            lat = CNT_W'(LAT_SQRT);
        end else if ((op >> 2) == OP_W'(OP_FMA_PFX) && LAT_FMA > 1) begin
            cls = FMA;
            lat = CNT_W'(LAT_FMA);
        end
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// FPU issue controller: stalls the core for the op-class latency, then pulses done.
// Latency: done registered 1 cycle after start (SINGLE) or N+1 cycles (N-cycle class).
// Holds in HOLD until start drops so a still-asserted start is never re-issued.
module fpu_seq_ctrl
    import fpu_seq_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_FMA  = 3,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          reset,
    fpu_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    op_class_e        op_cls;
    logic [CNT_W-1:0] op_lat;
    logic             multi;
    logic             in_sel, reg_ab_en, busy, stall;

    fpu_op_class_dec #(
        .OP_W    (OP_W),
        .CNT_W   (CNT_W),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .LAT_SQRT(LAT_SQRT),
        .LAT_FMA (LAT_FMA)
    ) u_dec (
        .op (bus.op),
        .cls(op_cls),
        .lat(op_lat)
    );

    assign multi = (op_cls != SINGLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        done_d    = 1'b0;
        in_sel    = 1'b1;
        reg_ab_en = 1'b1;
        busy      = 1'b0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q high in IDLE means a SINGLE op just finished: a held start is the same op
                if (done_q) begin
                    if (bus.start) state_d = HOLD;
                end else if (bus.start) begin
                    if (multi) begin
                        state_d = EXEC;
                        cnt_d   = op_lat - CNT_W'(1);
                        stall   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                in_sel    = 1'b0;
                reg_ab_en = 1'b0;
                busy      = 1'b1;
                stall     = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                in_sel    = 1'b0;
                reg_ab_en = 1'b0;
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            if (state_q == IDLE) stall = 1'b0;
        end
        if (reset) stall = 1'b0;
    end

    assign bus.in_sel    = in_sel;
    assign bus.reg_AB_en = reg_ab_en;
    assign bus.busy      = busy;
    assign bus.stall     = stall;
    assign bus.done      = done_q;
    assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: default-parameter instance plus a LAT_FMA=1 / LAT_DIV=15 instance.
module tb_fpu_seq_ctrl;
    import fpu_seq_pkg::*;

    localparam logic [4:0] OP_FADD = 5'b00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_seq_ctrl_if #(.OP_W(5), .CNT_W(4)) if0 ();
    fpu_seq_ctrl_if #(.OP_W(5), .CNT_W(4)) if1 ();

    fpu_seq_ctrl dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (if0.slave)
    );

    fpu_seq_ctrl #(.LAT_FMA(1), .LAT_DIV(15), .CNT_W(4)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (if1.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int q0[$];
    int q1[$];
    int exp0, exp1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the cycle predicted when the op was driven
    always @(negedge clk) begin
        if (!reset && if0.done) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL done0_unexpected: got done=1 at cyc %0d want no done", cyc);
            end else begin
                exp0 = q0.pop_front();
                if (exp0 != cyc) begin
                    errors++;
                    $display("FAIL done0_cycle: got cyc %0d want cyc %0d", cyc, exp0);
                end
            end
        end
        if (!reset && if1.done) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL done1_unexpected: got done=1 at cyc %0d want no done", cyc);
            end else begin
                exp1 = q1.pop_front();
                if (exp1 != cyc) begin
                    errors++;
                    $display("FAIL done1_cycle: got cyc %0d want cyc %0d", cyc, exp1);
                end
            end
        end
    end

    typedef struct {
        logic       start;
        logic [4:0] op;
        logic       flush;
        logic       in_sel;
        logic       busy;
        logic       stall;
        logic       done;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic [4:0] o, input logic f,
                                input logic isel, input logic b, input logic st,
                                input logic d, input logic [3:0] c);
        vec_t v;
        v.start = s; v.op = o; v.flush = f;
        v.in_sel = isel; v.busy = b; v.stall = st; v.done = d; v.cnt = c;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] outs0();
        return {23'd0, if0.in_sel, if0.reg_AB_en, if0.busy, if0.stall, if0.done, if0.cnt};
    endfunction

    function automatic logic [31:0] outs1();
        return {23'd0, if1.in_sel, if1.reg_AB_en, if1.busy, if1.stall, if1.done, if1.cnt};
    endfunction

    function automatic logic [31:0] mkexp(input logic isel, input logic b, input logic st,
                                          input logic d, input logic [3:0] c);
        return {23'd0, isel, isel, b, st, d, c};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if0.start = 1'b1; if0.op = OP_FDIV; if0.flush = 1'b0;
        if1.start = 1'b0; if1.op = OP_FADD; if1.flush = 1'b0;

        // start asserted during reset must be ignored
        #3;
        chk("reset_outs0", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        chk("reset_outs1", outs1(), mkexp(1, 0, 0, 0, 4'd0));
        tick(1);
        chk("reset_hold_start", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        if0.start = 1'b0;
        reset = 1'b0;
        tick(2);

        // FMUL with held start, SINGLE pulse, SINGLE held, flush+start in IDLE
        tbl.push_back(mk(1, OP_FMUL, 0,  1, 0, 1, 0, 4'd0));
        tbl.push_back(mk(1, OP_FMUL, 0,  0, 1, 1, 0, 4'd1));
        tbl.push_back(mk(1, OP_FMUL, 0,  0, 1, 1, 0, 4'd0));
        tbl.push_back(mk(1, OP_FMUL, 0,  0, 0, 0, 1, 4'd0));
        tbl.push_back(mk(1, OP_FMUL, 0,  0, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FMUL, 0,  0, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FADD, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, OP_FADD, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FADD, 0,  1, 0, 0, 1, 4'd0));
        tbl.push_back(mk(0, OP_FADD, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, OP_FADD, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, OP_FADD, 0,  1, 0, 0, 1, 4'd0));
        tbl.push_back(mk(1, OP_FADD, 0,  0, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FADD, 0,  0, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FADD, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, OP_FDIV, 1,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FDIV, 0,  1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, OP_FDIV, 0,  1, 0, 0, 0, 4'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            if0.start = tbl[i].start;
            if0.op    = tbl[i].op;
            if0.flush = tbl[i].flush;
            if (tbl[i].done) q0.push_back(cyc);
            #1;
            chk($sformatf("vec%0d", i), outs0(),
                mkexp(tbl[i].in_sel, tbl[i].busy, tbl[i].stall, tbl[i].done, tbl[i].cnt));
            @(posedge clk);
            #1;
        end

        // FDIV: 8-cycle countdown, then a held start with a new op must not re-issue
        if0.start = 1'b1; if0.op = OP_FDIV;
        q0.push_back(cyc + 9);
        tick(1);
        for (int k = 7; k >= 0; k--) begin
            chk($sformatf("fdiv_cnt%0d", k), {27'd0, if0.busy, if0.cnt}, {27'd0, 1'b1, 4'(k)});
            tick(1);
        end
        chk("fdiv_done_hold", outs0(), mkexp(0, 0, 0, 1, 4'd0));
        if0.op = OP_FADD;
        tick(1);
        chk("hold_no_reissue", outs0(), mkexp(0, 0, 0, 0, 4'd0));
        if0.start = 1'b0;
        tick(1);
        if0.start = 1'b1;
        q0.push_back(cyc + 1);
        tick(1);
        if0.start = 1'b0;
        chk("fadd_after_div", outs0(), mkexp(1, 0, 0, 1, 4'd0));
        tick(2);

        // FSQRT flushed at cnt=3: back to IDLE, no done
        if0.start = 1'b1; if0.op = OP_FSQRT;
        tick(5);
        chk("fsqrt_cnt3", {28'd0, if0.cnt}, 32'd3);
        if0.flush = 1'b1;
        tick(1);
        if0.flush = 1'b0; if0.start = 1'b0;
        chk("flush_exec", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        tick(10);

        // flush on the last EXEC cycle suppresses done
        if0.start = 1'b1; if0.op = OP_FMUL;
        tick(2);
        chk("fmul_last_exec", outs0(), mkexp(0, 1, 1, 0, 4'd0));
        if0.flush = 1'b1;
        tick(1);
        if0.flush = 1'b0; if0.start = 1'b0;
        chk("flush_last", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        tick(4);

        // async reset in the middle of EXEC
        if0.start = 1'b1; if0.op = OP_FDIV;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_exec", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        @(posedge clk);
        #1;
        chk("reset_held_start", outs0(), mkexp(1, 0, 0, 0, 4'd0));
        if0.start = 1'b0;
        reset = 1'b0;
        tick(12);

        // LAT_FMA=1 instance: FMA op behaves as SINGLE
        if1.start = 1'b1; if1.op = 5'b10010;
        #1;
        chk("fma1_no_stall", outs1(), mkexp(1, 0, 0, 0, 4'd0));
        q1.push_back(cyc);
        q1[0] = q1[0] + 1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        chk("fma1_done", outs1(), mkexp(1, 0, 0, 1, 4'd0));
        tick(2);

        // LAT_DIV=15 with CNT_W=4: full-range countdown, no wrap
        if1.start = 1'b1; if1.op = OP_FDIV;
        q1.push_back(cyc + 16);
        tick(1);
        if1.start = 1'b0;
        for (int k = 14; k >= 0; k--) begin
            chk($sformatf("div15_cnt%0d", k), {27'd0, if1.busy, if1.cnt}, {27'd0, 1'b1, 4'(k)});
            tick(1);
        end
        chk("div15_done", outs1(), mkexp(0, 0, 0, 1, 4'd0));
        tick(1);
        chk("div15_idle", outs1(), mkexp(1, 0, 0, 0, 4'd0));
        tick(3);

        chk("sb0_empty", q0.size(), 32'd0);
        chk("sb1_empty", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
